// File: rtl/naval_battle_engine.sv
// Clocked battleship engine: latches a ship map, resolves shots and runs the PREP/ATTACK/WIN/LOSE flow.
// Build option: define SHOT_LIMIT_EN to enable the shot budget (shots_left countdown and LOSE).
module naval_battle_engine #(
  parameter int unsigned COLS      = 5,
  parameter int unsigned ROWS      = 7,
  parameter int unsigned MAX_SHOTS = 20,
  localparam int unsigned N  = COLS * ROWS,
  localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = $clog2(N + 1),
  localparam int unsigned SW = $clog2(MAX_SHOTS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  map_in,
  input  logic          start,
  input  logic          confirm_attack,
  input  logic [XW-1:0] x_coord,
  input  logic [YW-1:0] y_coord,
  output logic [1:0]    state,
  output logic [N-1:0]  hit_map,
  output logic [N-1:0]  miss_map,
  output logic [N-1:0]  image,
  output logic [CW-1:0] ships_left,
  output logic [SW-1:0] shots_left,
  output logic [2:0]    led_rgb
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] LED_OFF  = 3'b000;
  localparam logic [2:0] LED_INV  = 3'b100;
  localparam logic [2:0] LED_REP  = 3'b110;
  localparam logic [2:0] LED_HIT  = 3'b010;
  localparam logic [2:0] LED_MISS = 3'b001;
  localparam logic [2:0] LED_WIN  = 3'b011;
  localparam logic [2:0] LED_LOSE = 3'b101;

  typedef enum logic [1:0] {
    PREP   = 2'b00,
    ATTACK = 2'b01,
    WIN    = 2'b10,
    LOSE   = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  hit_q, hit_d;
  logic [N-1:0]  miss_q, miss_d;
  logic [N-1:0]  map_q, map_d;
  logic [CW-1:0] ships_q, ships_d;
  logic [2:0]    led_q, led_d;
  logic          start_s_q, start_p_q, conf_s_q, conf_p_q;
  logic          start_ev_c, conf_ev_c, coord_ok_c, shot_c;
  logic [IW-1:0] idx_c;

  // Synchroniser stage plus previous-value stage; both preset so a held input gives no event.
  assign start_ev_c = start_s_q & ~start_p_q;
  assign conf_ev_c  = conf_s_q & ~conf_p_q;
  assign coord_ok_c = (32'(x_coord) < COLS) && (32'(y_coord) < ROWS);
  assign idx_c      = IW'(x_coord) * IW'(ROWS) + IW'(y_coord);

`ifdef SHOT_LIMIT_EN
  logic [SW-1:0] shots_q, shots_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shots_q <= SW'(MAX_SHOTS);
    else       shots_q <= shots_d;
  end

  assign shots_left = shots_q;
`else
  assign shots_left = SW'(MAX_SHOTS);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PREP;
      hit_q     <= '0;
      miss_q    <= '0;
      map_q     <= '0;
      ships_q   <= '0;
      led_q     <= LED_OFF;
      start_s_q <= 1'b1;
      start_p_q <= 1'b1;
      conf_s_q  <= 1'b1;
      conf_p_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      map_q     <= map_d;
      ships_q   <= ships_d;
      led_q     <= led_d;
      start_s_q <= start;
      start_p_q <= start_s_q;
      conf_s_q  <= confirm_attack;
      conf_p_q  <= conf_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    map_d   = map_q;
    ships_d = ships_q;
    led_d   = led_q;
    shot_c  = 1'b0;
`ifdef SHOT_LIMIT_EN
    shots_d = shots_q;
`endif
    unique case (state_q)
      PREP: begin
        if (start_ev_c) begin
          map_d   = map_in;
          ships_d = CW'($countones(map_in));
          hit_d   = '0;
          miss_d  = '0;
          led_d   = LED_OFF;
`ifdef SHOT_LIMIT_EN
          shots_d = SW'(MAX_SHOTS);
`endif
          if (map_in == '0) led_d = LED_INV;
          else              state_d = ATTACK;
        end
      end
      ATTACK: begin
        if (conf_ev_c) begin
          if (!coord_ok_c) begin
            led_d = LED_INV;
          end else if (hit_q[idx_c] || miss_q[idx_c]) begin
            led_d = LED_REP;
          end else begin
            shot_c = 1'b1;
            if (map_q[idx_c]) begin
              hit_d[idx_c] = 1'b1;
              if (ships_q != '0) ships_d = ships_q - CW'(1);
              led_d = LED_HIT;
            end else begin
              miss_d[idx_c] = 1'b1;
              led_d = LED_MISS;
            end
`ifdef SHOT_LIMIT_EN
            if (shots_q != '0) shots_d = shots_q - SW'(1);
`endif
          end
          // Sinking the last ship outranks running out of shots.
          if (shot_c && ships_d == '0) begin
            state_d = WIN;
            led_d   = LED_WIN;
          end
`ifdef SHOT_LIMIT_EN
          else if (shot_c && shots_d == '0) begin
            state_d = LOSE;
            led_d   = LED_LOSE;
          end
`endif
        end
      end
      default: begin
        if (start_ev_c) begin
          state_d = PREP;
          hit_d   = '0;
          miss_d  = '0;
          map_d   = '0;
          ships_d = '0;
          led_d   = LED_OFF;
`ifdef SHOT_LIMIT_EN
          shots_d = SW'(MAX_SHOTS);
`endif
        end
      end
    endcase
  end

  always_comb begin
    unique case (state_q)
      PREP:    image = map_in;
      ATTACK:  image = hit_q | miss_q;
      default: image = map_q;
    endcase
  end

  assign state      = state_q;
  assign hit_map    = hit_q;
  assign miss_map   = miss_q;
  assign ships_left = ships_q;
  assign led_rgb    = led_q;

endmodule

// File: tb/tb_naval_battle_engine.sv
// Scoreboard bench for naval_battle_engine: cell-array game model predicts, a negedge monitor compares.
module tb_naval_battle_engine;
  localparam int COLS = 5;
  localparam int ROWS = 7;
  localparam int MAX_SHOTS = 20;
  localparam int N  = COLS * ROWS;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int CW = 6;
  localparam int SW = 5;
`ifdef SHOT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  localparam int M_PREP = 0, M_ATTACK = 1, M_WIN = 2, M_LOSE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] map_in = '0;
  logic start = 1'b0, confirm_attack = 1'b0;
  logic [XW-1:0] x_coord = '0;
  logic [YW-1:0] y_coord = '0;
  logic [1:0] state;
  logic [N-1:0] hit_map, miss_map, image;
  logic [CW-1:0] ships_left;
  logic [SW-1:0] shots_left;
  logic [2:0] led_rgb;

  naval_battle_engine #(.COLS(COLS), .ROWS(ROWS), .MAX_SHOTS(MAX_SHOTS)) dut (
    .clk(clk), .reset(reset), .map_in(map_in), .start(start),
    .confirm_attack(confirm_attack), .x_coord(x_coord), .y_coord(y_coord),
    .state(state), .hit_map(hit_map), .miss_map(miss_map), .image(image),
    .ships_left(ships_left), .shots_left(shots_left), .led_rgb(led_rgb)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   due;
    string         tag;
    logic [1:0]    st;
    logic [N-1:0]  hit, miss, img;
    logic [CW-1:0] ships;
    logic [SW-1:0] shots;
    logic [2:0]    led;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Game model: per-cell ship / hit / miss flags; counts derived from the cells.
  int mst = M_PREP;
  bit mship[N];
  bit mhit[N];
  bit mmiss[N];
  logic [2:0] mled = 3'b000;

  function automatic int ships_rem();
    int n = 0;
    for (int i = 0; i < N; i++) if (mship[i] && !mhit[i]) n++;
    return n;
  endfunction

  function automatic int shots_rem();
    int n = 0;
    if (!LIMIT) return MAX_SHOTS;
    for (int i = 0; i < N; i++) if (mhit[i] || mmiss[i]) n++;
    return MAX_SHOTS - n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mship[i] = 1'b0; mhit[i] = 1'b0; mmiss[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input bit s, input bit c, input int x, input int y, input logic [N-1:0] m);
    int i;
    if (mst == M_PREP) begin
      if (s) begin
        model_clear();
        for (int k = 0; k < N; k++) mship[k] = m[k];
        if (m == '0) mled = 3'b100;
        else begin mled = 3'b000; mst = M_ATTACK; end
      end
    end else if (mst == M_ATTACK) begin
      if (c) begin
        if (x >= COLS || y >= ROWS) mled = 3'b100;
        else begin
          i = x * ROWS + y;
          if (mhit[i] || mmiss[i]) mled = 3'b110;
          else begin
            if (mship[i]) begin mhit[i] = 1'b1; mled = 3'b010; end
            else begin mmiss[i] = 1'b1; mled = 3'b001; end
            if (ships_rem() == 0) begin mst = M_WIN; mled = 3'b011; end
            else if (shots_rem() == 0) begin mst = M_LOSE; mled = 3'b101; end
          end
        end
      end
    end else if (s) begin
      model_clear();
      mst = M_PREP;
      mled = 3'b000;
    end
  endtask

  task automatic push(input string tag, input int d, input logic [N-1:0] m);
    exp_t e;
    e.due = cyc + d;
    e.tag = tag;
    e.st = 2'(mst);
    for (int i = 0; i < N; i++) begin
      e.hit[i] = mhit[i];
      e.miss[i] = mmiss[i];
    end
    e.ships = CW'(ships_rem());
    e.shots = SW'(shots_rem());
    e.led = mled;
    if (mst == M_PREP) e.img = m;
    else if (mst == M_ATTACK) e.img = e.hit | e.miss;
    else for (int i = 0; i < N; i++) e.img[i] = mship[i];
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h cyc=%0d", tag, fld, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT snapshot whenever an expectation falls due.
  always @(negedge clk) begin
    if (q.size() > 0 && cyc >= q[0].due) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "state", 64'(state), 64'(e.st));
      chk(e.tag, "hit_map", 64'(hit_map), 64'(e.hit));
      chk(e.tag, "miss_map", 64'(miss_map), 64'(e.miss));
      chk(e.tag, "image", 64'(image), 64'(e.img));
      chk(e.tag, "ships_left", 64'(ships_left), 64'(e.ships));
      chk(e.tag, "shots_left", 64'(shots_left), 64'(e.shots));
      chk(e.tag, "led_rgb", 64'(led_rgb), 64'(e.led));
    end
  end

  task automatic drain();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
      q.delete();
    end
  endtask

  task automatic op(input bit s, input bit c, input int x, input int y, input logic [N-1:0] m, input string tag);
    @(negedge clk);
    map_in = m;
    x_coord = XW'(x);
    y_coord = YW'(y);
    start = s;
    confirm_attack = c;
    model_apply(s, c, x, y, m);
    push(tag, 2, m);
    @(negedge clk);
    start = 1'b0;
    confirm_attack = 1'b0;
    drain();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    mst = M_PREP;
    mled = 3'b000;
    push(tag, 1, map_in);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drain();
  endtask

  task automatic new_game(input logic [N-1:0] m, input string tag);
    if (mst == M_ATTACK) do_reset({tag, "_rst"});
    if (mst != M_PREP) op(1, 0, 0, 0, m, {tag, "_toprep"});
    op(1, 0, 0, 0, m, tag);
  endtask

  logic [N-1:0] map2, rmap;
  int misses;

  initial begin
    map2 = '0;
    map2[0] = 1'b1;
    map2[8] = 1'b1;

    // Start held high through reset must not begin a game.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    map_in = N'(1) << 8;
    model_clear();
    push("reset", 1, map_in);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push("held_start", 1, map_in);
    drain();
    start = 1'b0;
    op(1, 0, 0, 0, N'(1) << 8, "start1");

    new_game(map2, "start2");
    op(0, 1, 1, 1, map2, "hit_1_1");
    op(0, 1, 0, 0, map2, "win");
    op(0, 1, 2, 3, map2, "confirm_in_win");

    new_game(map2, "start3");
    op(0, 1, 2, 3, map2, "miss_2_3");
    op(0, 1, 2, 3, map2, "repeat_2_3");
    op(0, 1, 5, 0, map2, "bad_x");
    op(0, 1, 0, 7, map2, "bad_y");
    op(1, 0, 0, 0, '0, "start_in_attack");
    op(1, 1, 1, 1, map2, "simul_attack");

`ifdef SHOT_LIMIT_EN
    new_game(N'(1) << 8, "start5");
    misses = 0;
    for (int i = 0; i < N && misses < 20; i++) begin
      if (i != 8) begin
        op(0, 1, i / ROWS, i % ROWS, N'(1) << 8, "miss_run");
        misses++;
      end
    end
    op(0, 1, 1, 1, N'(1) << 8, "confirm_in_lose");
    op(1, 0, 0, 0, N'(1) << 8, "lose_to_prep");
`else
    new_game(N'(1) << 8, "start6");
    misses = 0;
    for (int i = 0; i < N && misses < 25; i++) begin
      if (i != 8) begin
        op(0, 1, i / ROWS, i % ROWS, N'(1) << 8, "miss_run");
        misses++;
      end
    end
`endif
    new_game('0, "empty_map");

    // Randomised games, including restarts, simultaneous events and mid-game resets.
    for (int g = 0; g < 8; g++) begin
      rmap = '0;
      if (g != 3)
        for (int i = 0; i < N; i++) rmap[i] = ($urandom_range(0, 4) == 0);
      new_game(rmap, "rnd_start");
      for (int s = 0; s < 70 && mst == M_ATTACK; s++) begin
        op(($urandom_range(0, 7) == 0), 1'b1, $urandom_range(0, 5), $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0) ? N'($urandom) : rmap, "rnd_shot");
      end
      if (mst == M_ATTACK && g[0]) do_reset("rnd_midreset");
    end

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
